// File: rtl/div_unit.sv
// 32-bit restoring divider, signed by default; DIV_UNSIGNED_EN adds unsigned start (divControl=10).
// Fixed 34-edge latency from start to done, abortable with divControl=11.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  divControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_q;
    logic [31:0] r_b;
    logic [31:0] r_rem;
    logic [4:0]  r_cnt;
    logic        r_sgn;
    logic        r_negq;
    logic        r_negr;

    logic        w_start_s;
    logic        w_start_u;
    logic        w_start;
    logic        w_abort;
    logic        w_bzero;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_div0_nxt;
    logic        w_wr;
    logic [32:0] w_sh;
    logic [32:0] w_diff;

    assign w_start_s = (divControl == 2'b01);
`ifdef DIV_UNSIGNED_EN
    assign w_start_u = (divControl == 2'b10);
`else
    assign w_start_u = 1'b0;
`endif
    assign w_start = w_start_s | w_start_u;
    assign w_abort = (divControl == 2'b11);
    assign w_bzero = (r_b == 32'd0);

    // Partial remainder is 33 bits wide; bit 32 of the difference is the borrow.
    assign w_sh   = {r_rem, r_q[31]};
    assign w_diff = w_sh - {1'b0, r_b};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            div0    <= 1'b0;
        end else begin
            r_state <= w_next;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
            div0    <= w_div0_nxt;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_start) w_next = S_PREP;
            S_PREP: begin
                if (w_abort || w_bzero) w_next = S_IDLE;
                else                    w_next = S_RUN;
            end
            S_RUN: begin
                if (w_abort)            w_next = S_IDLE;
                else if (r_cnt == 5'd0) w_next = S_FIX;
            end
            S_FIX: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_div0_nxt = 1'b0;
        w_wr       = 1'b0;
        unique case (r_state)
            S_IDLE: w_busy_nxt = w_start;
            S_PREP: begin
                w_busy_nxt = !w_abort && !w_bzero;
                w_div0_nxt = !w_abort && w_bzero;
            end
            S_RUN: w_busy_nxt = !w_abort;
            S_FIX: begin
                w_done_nxt = !w_abort;
                w_wr       = !w_abort;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= 32'd0;
            r_b    <= 32'd0;
            r_rem  <= 32'd0;
            r_cnt  <= 5'd0;
            r_sgn  <= 1'b0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_q   <= A;
                        r_b   <= B;
                        r_sgn <= w_start_s;
                    end
                end
                S_PREP: begin
                    if (!w_abort && !w_bzero) begin
                        r_q    <= (r_sgn && r_q[31]) ? -r_q : r_q;
                        r_b    <= (r_sgn && r_b[31]) ? -r_b : r_b;
                        r_negq <= r_sgn && (r_q[31] ^ r_b[31]);
                        r_negr <= r_sgn && r_q[31];
                        r_rem  <= 32'd0;
                        r_cnt  <= 5'd31;
                    end
                end
                S_RUN: begin
                    if (!w_abort) begin
                        r_rem <= w_diff[32] ? w_sh[31:0] : w_diff[31:0];
                        r_q   <= {r_q[30:0], ~w_diff[32]};
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_FIX: begin
                    if (w_wr) begin
                        lo <= r_negq ? -r_q : r_q;
                        hi <= r_negr ? -r_rem : r_rem;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port divControl, input, 2 bits: command from Control; 00 no-op, 01 start signed, 10 start unsigned (see REQ-026), 11 abort.
REQ-004 SHALL have port A, input, 32 bits: dividend; sampled only on the start edge.
REQ-005 SHALL have port B, input, 32 bits: divisor; sampled only on the start edge.
REQ-006 SHALL have port hi, output, 32 bits: remainder register, to HI datapath mux.
REQ-007 SHALL have port lo, output, 32 bits: quotient register, to LO datapath mux.
REQ-008 SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse; hi/lo valid and newly written.
REQ-010 SHALL have port div0, output, 1 bit: one-cycle pulse; divisor was zero; feeds Control div0.

Function
REQ-011 SHALL implement states IDLE, PREP, RUN, FIX; all outputs registered.
REQ-012 IDLE: divControl=01 at edge E0 SHALL capture A, B and sign mode, set busy=1, go to PREP; 00 and 11 SHALL be ignored.
REQ-013 PREP, at edge E1: if captured B==0, SHALL set div0=1, busy=0, go to IDLE, hi/lo unchanged; else SHALL form absolute values (signed mode), clear remainder, load 5-bit count=31, go to RUN.
REQ-014 RUN: one restoring shift-subtract iteration per edge, E2..E33 (32 iterations); after count 0 SHALL go to FIX.
REQ-015 FIX, at edge E34: SHALL apply sign correction and write lo and hi, pulse done=1, set busy=0, go to IDLE.
REQ-016 Total latency SHALL be 34 edges from start to done; done and div0 SHALL each be high for exactly one cycle.
REQ-017 Signed results SHALL truncate toward zero: quotient negative iff operand signs differ; remainder sign equals dividend sign; A = lo*B + hi always holds (mod 2^32).
REQ-018 0x80000000 / 0xFFFFFFFF (signed) SHALL give lo=0x80000000, hi=0, no exception.
REQ-019 Start commands while busy=1 SHALL be ignored; operands SHALL not be resampled.
REQ-020 divControl=11 while busy=1 (PREP/RUN/FIX) SHALL force IDLE on the next edge, busy=0, no done, no div0, hi/lo unchanged; 11 in FIX SHALL take priority over the write.
REQ-021 hi/lo SHALL hold their values indefinitely except at a FIX write or reset.
REQ-022 Back-to-back: a start presented at the edge after done SHALL be accepted (IDLE already reached).

Reset
REQ-023 reset=0 SHALL immediately, without clk, force state IDLE, hi=0, lo=0, busy=0, done=0, div0=0, internal count/remainder/operands=0.
REQ-024 Reset asserted mid-operation SHALL abandon it; no done or div0 SHALL follow after release.
REQ-025 After reset release, the first rising edge SHALL already accept a start.

Configuration
REQ-026 Macro DIV_UNSIGNED_EN: defined -> divControl=10 starts an unsigned division (no absolute value or sign correction, same 34-edge timing); undefined -> 10 SHALL be treated as no-op in every state.

Verification
REQ-027 Signed 7/2: A=7, B=2, divControl=01 -> lo=3, hi=1, done 34 edges after start.
REQ-028 Signed -7/2: A=0xFFFFFFF9, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-029 Divide by zero: A=5, B=0 -> div0=1 for one cycle after E1, busy=0, no done, hi/lo retain prior values.
REQ-030 Abort and ignore: start 100/7, re-issue 01 with B=1 at E10, then 11 at E20 -> busy=0 at E21, no done, hi/lo unchanged; next start 100/7 -> lo=14, hi=2.
REQ-031 Async reset at E15 of a division -> outputs zero immediately, no done afterwards; with DIV_UNSIGNED_EN, 0xFFFFFFFF/2 (10) -> lo=0x7FFFFFFF, hi=1; without it, 10 -> busy stays 0.
